// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter : two-port (core / DMA) arbiter in front of the data memory.   |
// | Optional macro DMEM_ARB_RR_EN selects round-robin instead of core priority. |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+

package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    MEM_DISABLED = 2'b00,
    MEM_READ     = 2'b01,
    MEM_WRITE    = 2'b10
  } memaccess_t;

  // First word address past the end of the data memory.
  localparam logic [29:0] DMEM_WORD = 30'd1024;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        start,

  input  logic        c_req,
  input  memaccess_t  c_memaccess,
  input  logic [29:0] c_word_addr,
  input  logic [3:0]  c_wstrb,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_fault,

  input  logic        d_req,
  input  memaccess_t  d_memaccess,
  input  logic [29:0] d_word_addr,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault,

  output memaccess_t  m_memaccess,
  output logic [29:0] m_word_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_fault,

  output logic        busy
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_owner_dma;
  logic   w_grant;
  logic   w_dma_wins;

  assign w_grant = ((r_state == S_IDLE) || (r_state == S_RESP)) && (c_req || d_req);

`ifdef DMEM_ARB_RR_EN
  // Set after a DMA grant; reset value makes the core win the first tie.
  logic r_last_dma;

  assign w_dma_wins = d_req && (!c_req || !r_last_dma);

  always_ff @(posedge clk) begin
    if (!start) begin
      r_last_dma <= 1'b1;
    end else if (w_grant) begin
      r_last_dma <= w_dma_wins;
    end
  end
`else
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  assign w_dma_wins = d_req && (!c_req || (r_starve == c_starve_limit));

  // Counts core grants taken while DMA waits; any cycle without a DMA request clears it.
  always_ff @(posedge clk) begin
    if (!start) begin
      r_starve <= 4'd0;
    end else if (!d_req) begin
      r_starve <= 4'd0;
    end else if (w_grant) begin
      r_starve <= w_dma_wins ? 4'd0 : r_starve + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!start) begin
      r_state     <= S_BOOT;
      r_owner_dma <= 1'b0;
      c_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      c_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
      m_memaccess <= MEM_DISABLED;
      m_word_addr <= 30'd0;
      m_wstrb     <= 4'd0;
      m_wdata     <= 32'd0;
    end else begin
      c_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      c_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
      m_memaccess <= MEM_DISABLED;
      case (r_state)
        S_BOOT: begin
          r_state <= S_IDLE;
        end
        S_ISSUE: begin
          r_state  <= S_RESP;
          c_rvalid <= !r_owner_dma;
          d_rvalid <= r_owner_dma;
        end
        S_IDLE, S_RESP: begin
          if (w_grant) begin
            r_state     <= S_ISSUE;
            r_owner_dma <= w_dma_wins;
            c_gnt       <= !w_dma_wins;
            d_gnt       <= w_dma_wins;
            if (w_dma_wins) begin
              m_memaccess <= d_memaccess;
              m_word_addr <= d_word_addr;
              m_wstrb     <= d_wstrb;
              m_wdata     <= d_wdata;
            end else begin
              m_memaccess <= c_memaccess;
              m_word_addr <= c_word_addr;
              m_wstrb     <= c_wstrb;
              m_wdata     <= c_wdata;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  // Memory response is valid during RESP, so it is steered by the registered rvalid.
  assign c_rdata = c_rvalid ? m_rdata : 32'd0;
  assign d_rdata = d_rvalid ? m_rdata : 32'd0;
  assign c_fault = c_rvalid & m_fault;
  assign d_fault = d_rvalid & m_fault;
  assign busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed and randomized bench for dmem_arbiter.           |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        start;
  logic        c_req, d_req;
  memaccess_t  c_memaccess, d_memaccess;
  logic [29:0] c_word_addr, d_word_addr;
  logic [3:0]  c_wstrb, d_wstrb;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, c_fault, d_fault;
  logic [31:0] c_rdata, d_rdata;
  memaccess_t  m_memaccess;
  logic [29:0] m_word_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_fault;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .start(start),
    .c_req(c_req), .c_memaccess(c_memaccess), .c_word_addr(c_word_addr),
    .c_wstrb(c_wstrb), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata), .c_fault(c_fault),
    .d_req(d_req), .d_memaccess(d_memaccess), .d_word_addr(d_word_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_fault(d_fault),
    .m_memaccess(m_memaccess), .m_word_addr(m_word_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_fault(m_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data memory: response one cycle after the access, fault beyond DMEM_WORD, cleared in reset.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    m_rdata <= 32'd0;
    m_fault <= 1'b0;
    if (!start) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    end else if (m_memaccess != MEM_DISABLED) begin
      if (m_word_addr >= DMEM_WORD) begin
        m_fault <= 1'b1;
      end else if (m_memaccess == MEM_WRITE) begin
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) mem[m_word_addr[9:0]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_word_addr[9:0]];
      end
    end
  end

  logic [31:0] ref_mem [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
  endtask

  // One complete transaction on one port; returns the response sampled in RESP.
  task automatic txn(input bit dma, input memaccess_t acc, input logic [29:0] a,
                     input logic [3:0] s, input logic [31:0] w,
                     output logic [31:0] rd, output logic fl);
    int n;
    if (dma) begin
      d_memaccess = acc; d_word_addr = a; d_wstrb = s; d_wdata = w; d_req = 1'b1;
    end else begin
      c_memaccess = acc; c_word_addr = a; c_wstrb = s; c_wdata = w; c_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dma ? d_gnt : c_gnt) && n < 20);
    chk(dma ? "txn_d_gnt" : "txn_c_gnt", dma ? d_gnt : c_gnt, 1);
    c_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk(dma ? "txn_d_rvalid" : "txn_c_rvalid", dma ? d_rvalid : c_rvalid, 1);
    rd = dma ? d_rdata : c_rdata;
    fl = dma ? d_fault : c_fault;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        fl;
    bit          seq [0:9];
    int          n;
    bit          cp, dp, dp_edge, w, exp_w, last_dma;
    int          streak, stall, max_stall;
    bit          pc_resp, pd_resp, pc_read, pd_read;
    logic [31:0] pc_data, pd_data;
    logic        pc_fault, pd_fault;
    logic [29:0] a;

    start = 1'b0;
    c_req = 1'b0; c_memaccess = MEM_READ; c_word_addr = '0; c_wstrb = '0; c_wdata = '0;
    d_req = 1'b0; d_memaccess = MEM_READ; d_word_addr = '0; d_wstrb = '0; d_wdata = '0;
    clear_ref();

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_fault", d_fault, 0);
    chk("rst_m_memaccess", m_memaccess, MEM_DISABLED);
    chk("rst_m_word_addr", m_word_addr, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_m_wdata", m_wdata, 0);

    // Boot sequence with a core write already requested.
    c_memaccess = MEM_WRITE; c_word_addr = 30'h10; c_wstrb = 4'hF; c_wdata = 32'hDEADBEEF;
    c_req = 1'b1;
    start = 1'b1;
    #1;
    chk("boot_m_memaccess", m_memaccess, MEM_DISABLED);
    chk("boot_busy", busy, 1);
    chk("boot_c_gnt", c_gnt, 0);
    @(negedge clk);
    chk("idle_c_gnt", c_gnt, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("first_c_gnt", c_gnt, 1);
    chk("first_m_memaccess", m_memaccess, MEM_WRITE);
    chk("first_m_word_addr", m_word_addr, 30'h10);
    chk("first_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("first_m_wstrb", m_wstrb, 4'hF);
    c_req = 1'b0;
    @(negedge clk);
    chk("wr_c_rvalid", c_rvalid, 1);
    chk("wr_c_fault", c_fault, 0);
    chk("resp_m_memaccess", m_memaccess, MEM_DISABLED);
    chk("resp_hold_addr", m_word_addr, 30'h10);
    chk("resp_hold_wdata", m_wdata, 32'hDEADBEEF);
    chk("resp_busy", busy, 1);

    txn(1'b0, MEM_READ, 30'h10, 4'h0, 32'h0, rd, fl);
    chk("rd_c_rdata", rd, 32'hDEADBEEF);
    chk("rd_c_fault", fl, 0);
    chk("rd_d_rvalid", d_rvalid, 0);

    // Both ports continuously requesting from reset.
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    c_memaccess = MEM_READ; c_word_addr = 30'h1;
    d_memaccess = MEM_READ; d_word_addr = 30'h2;
    c_req = 1'b1; d_req = 1'b1;
    start = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      @(negedge clk);
      if (c_gnt) begin seq[n] = 1'b0; n++; end
      else if (d_gnt) begin seq[n] = 1'b1; n++; end
    end
    chk("order_count", n, 10);
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk($sformatf("order_%0d", i), seq[i], (i % 2) == 1);
`else
      chk($sformatf("order_%0d", i), seq[i], (i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
`endif
    end
    c_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);

    // DMA read past the end of memory.
    txn(1'b1, MEM_READ, DMEM_WORD, 4'h0, 32'h0, rd, fl);
    chk("oob_d_fault", fl, 1);
    chk("oob_d_rdata", rd, 0);
    chk("oob_c_rvalid", c_rvalid, 0);
    chk("oob_c_fault", c_fault, 0);
    chk("oob_c_rdata", c_rdata, 0);

    // Reset arriving while a core access is in ISSUE.
    @(negedge clk);
    c_memaccess = MEM_READ; c_word_addr = 30'h10; c_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!c_gnt && n < 20);
    chk("abort_c_gnt", c_gnt, 1);
    start = 1'b0;
    c_req = 1'b0;
    @(negedge clk);
    chk("abort_c_rvalid", c_rvalid, 0);
    chk("abort_d_rvalid", d_rvalid, 0);
    chk("abort_m_memaccess", m_memaccess, MEM_DISABLED);
    chk("abort_busy", busy, 1);
    start = 1'b1;
    #1;
    chk("abort_boot_busy", busy, 1);
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    clear_ref();

    // Randomized traffic against the reference model.
    cp = 0; dp = 0; streak = 0; last_dma = 1; stall = 0; max_stall = 0;
    pc_resp = 0; pd_resp = 0; pc_read = 0; pd_read = 0;
    pc_data = 0; pd_data = 0; pc_fault = 0; pd_fault = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      dp_edge = dp;
      chk("rnd_c_rvalid", c_rvalid, pc_resp);
      chk("rnd_d_rvalid", d_rvalid, pd_resp);
      if (pc_resp) begin
        chk("rnd_c_fault", c_fault, pc_fault);
        if (pc_read) chk("rnd_c_rdata", c_rdata, pc_data);
      end else begin
        chk("rnd_c_rdata_idle", c_rdata, 0);
      end
      if (pd_resp) begin
        chk("rnd_d_fault", d_fault, pd_fault);
        if (pd_read) chk("rnd_d_rdata", d_rdata, pd_data);
      end else begin
        chk("rnd_d_rdata_idle", d_rdata, 0);
      end
      pc_resp = 0; pd_resp = 0;
      chk("rnd_one_gnt", c_gnt & d_gnt, 0);
      if (c_gnt || d_gnt) begin
        w = d_gnt;
        if (cp && dp) begin
`ifdef DMEM_ARB_RR_EN
          exp_w = !last_dma;
`else
          exp_w = (streak == STARVE_LIMIT);
`endif
        end else begin
          exp_w = dp;
        end
        chk("rnd_gnt_pending", w ? dp : cp, 1);
        chk("rnd_winner", w, exp_w);
        chk("rnd_m_memaccess", m_memaccess, w ? d_memaccess : c_memaccess);
        chk("rnd_m_word_addr", m_word_addr, w ? d_word_addr : c_word_addr);
        chk("rnd_m_wdata", m_wdata, w ? d_wdata : c_wdata);
        chk("rnd_m_wstrb", m_wstrb, w ? d_wstrb : c_wstrb);
        a = w ? d_word_addr : c_word_addr;
        rd = 32'd0;
        fl = (a >= DMEM_WORD);
        if (!fl) begin
          if ((w ? d_memaccess : c_memaccess) == MEM_WRITE) begin
            for (int b = 0; b < 4; b++)
              if ((w ? d_wstrb[b] : c_wstrb[b]))
                ref_mem[a[9:0]][8*b +: 8] = w ? d_wdata[8*b +: 8] : c_wdata[8*b +: 8];
          end else begin
            rd = ref_mem[a[9:0]];
          end
        end
        if (w) begin
          pd_resp = 1; pd_read = (d_memaccess == MEM_READ); pd_data = rd; pd_fault = fl;
          streak = 0; dp = 0;
        end else begin
          pc_resp = 1; pc_read = (c_memaccess == MEM_READ); pc_data = rd; pc_fault = fl;
          if (dp_edge) streak++;
          cp = 0;
        end
        last_dma = w;
        stall = 0;
      end else begin
        chk("rnd_m_idle", m_memaccess, MEM_DISABLED);
        if (cp || dp) stall++;
        if (stall > max_stall) max_stall = stall;
      end
      if (!dp_edge) streak = 0;

      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1;
        c_memaccess = $urandom_range(0, 1) ? MEM_WRITE : MEM_READ;
        c_word_addr = ($urandom_range(0, 7) == 0) ? DMEM_WORD + 30'($urandom_range(0, 3))
                                                  : 30'($urandom_range(0, 15));
        c_wstrb = 4'($urandom);
        c_wdata = $urandom;
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1;
        d_memaccess = $urandom_range(0, 1) ? MEM_WRITE : MEM_READ;
        d_word_addr = ($urandom_range(0, 7) == 0) ? DMEM_WORD + 30'($urandom_range(0, 3))
                                                  : 30'($urandom_range(0, 15));
        d_wstrb = 4'($urandom);
        d_wdata = $urandom;
      end
      c_req = cp;
      d_req = dp;
    end
    chk("rnd_max_stall_ok", max_stall <= 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
